credit_receiver_mc: RTL and testbench

CREDIT_RECEIVER_MC -- requirements
Module: credit_receiver_mc

---
 rtl/credit_receiver_mc_pkg.sv | 18 +
 rtl/credit_receiver_counter.sv | 63 ++++++
 rtl/credit_receiver_mc.sv | 150 +++++++++++++++
 tb/tb_credit_receiver_mc.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/credit_receiver_mc_pkg.sv
// Shared definitions for the credit receiver: the receiver state encoding
// and the helper that sizes credit counters from their maximum value.
package credit_receiver_mc_pkg;

    typedef enum logic [1:0] {
        ST_RESET       = 2'd0,
        ST_SENDER_WAIT = 2'd1,
        ST_ACTIVE      = 2'd2
    } rxState_e;

    // Number of bits needed to hold every value 0..maxValue, never below one.
    function automatic int countWidth(input int maxValue);
        int w;
        w = $clog2(maxValue + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/credit_receiver_counter.sv
// Saturating up/down counter with synchronous load. The increment may be
// several units wide; the decrement is a single unit. Results below zero
// clamp to zero and results above MAX_VALUE clamp to MAX_VALUE, in which
// case saturated_o flags the clipped update for that cycle.
module credit_receiver_counter #(
    parameter int WIDTH      = 4,
    parameter int INCR_WIDTH = 1,
    parameter int MAX_VALUE  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable_i,
    input  logic                  load_i,
    input  logic [WIDTH-1:0]      loadValue_i,
    input  logic [INCR_WIDTH-1:0] incr_i,
    input  logic                  decr_i,
    output logic [WIDTH-1:0]      count_o,
    output logic                  saturated_o
);

    localparam int SUM_WIDTH = ((WIDTH > INCR_WIDTH) ? WIDTH : INCR_WIDTH) + 1;
    localparam logic [SUM_WIDTH-1:0] MAX_SUM = SUM_WIDTH'(MAX_VALUE);

    logic [WIDTH-1:0]     count_q;
    logic [WIDTH-1:0]     count_d;
    logic [SUM_WIDTH-1:0] grossSum;
    logic [SUM_WIDTH-1:0] netSum;

    // Next count: load wins, otherwise apply increment and decrement together and clamp.
    always_comb begin
        count_d     = count_q;
        saturated_o = 1'b0;
        grossSum    = SUM_WIDTH'(count_q) + SUM_WIDTH'(incr_i);
        netSum      = '0;
        if (load_i) begin
            count_d = loadValue_i;
        end else if (enable_i) begin
            if (grossSum < SUM_WIDTH'(decr_i)) begin
                count_d = '0;
            end else begin
                netSum = grossSum - SUM_WIDTH'(decr_i);
                if (netSum > MAX_SUM) begin
                    count_d     = WIDTH'(MAX_VALUE);
                    saturated_o = 1'b1;
                end else begin
                    count_d = netSum[WIDTH-1:0];
                end
            end
        end
    end

    // Count register, cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/credit_receiver_mc.sv
// Credit-based flow-control receiver. Holds credits freed by the downstream
// side, returns them one per cycle to the sender (minus a withheld reserve),
// and forwards sender data downstream with zero latency.
// Optional protocol checking is enabled by defining the macro
// CREDIT_RECEIVER_MC_ERROR_CHECK_EN; without it credit_error is tied low and
// no outstanding-credit counter is built.
module credit_receiver_mc
    import credit_receiver_mc_pkg::*;
#(
    parameter int  DATA_WIDTH          = 8,
    parameter int  MAX_CREDITS         = 8,
    parameter int  POP_CREDIT_MAX_INCR = 1,
    localparam int CW                  = countWidth(MAX_CREDITS),
    localparam int IW                  = countWidth(POP_CREDIT_MAX_INCR)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_sender_in_reset,
    output logic                  push_receiver_in_reset,
    input  logic                  push_credit_stall,
    output logic                  push_credit,
    input  logic                  push_valid,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic                  pop_valid,
    output logic [DATA_WIDTH-1:0] pop_data,
    input  logic [IW-1:0]         pop_credit,
    input  logic [CW-1:0]         credit_initial,
    input  logic [CW-1:0]         credit_withhold,
    output logic [CW-1:0]         credit_count,
    output logic [CW-1:0]         credit_available,
    output logic                  credit_error
);

    rxState_e state_q;
    rxState_e state_d;
    logic     isActive;
    logic     loadInitial;
    logic     countSat;

    // State register: the asynchronous reset parks the receiver in RESET.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: leave RESET at once, wait for the sender to come out of
    // reset, and fall back to waiting whenever the sender resets mid-run.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RESET:       state_d = ST_SENDER_WAIT;
            ST_SENDER_WAIT: if (!push_sender_in_reset) state_d = ST_ACTIVE;
            ST_ACTIVE:      if (push_sender_in_reset) state_d = ST_SENDER_WAIT;
            default:        state_d = ST_RESET;
        endcase
    end

    // Combinational outputs: withheld credits are never offered, one credit
    // goes back per cycle while active and unstalled, data passes straight through.
    always_comb begin
        isActive               = (state_q == ST_ACTIVE);
        loadInitial            = (state_q == ST_SENDER_WAIT);
        push_receiver_in_reset = (state_q == ST_RESET);
        credit_available       = '0;
        if (credit_count > credit_withhold) begin
            credit_available = credit_count - credit_withhold;
        end
        push_credit = isActive && !push_credit_stall && (credit_available != '0);
        pop_valid   = push_valid && isActive;
        pop_data    = push_data;
    end

    credit_receiver_counter #(
        .WIDTH      (CW),
        .INCR_WIDTH (IW),
        .MAX_VALUE  (MAX_CREDITS)
    ) creditCounter (
        .clk         (clk),
        .rst         (rst),
        .enable_i    (isActive),
        .load_i      (loadInitial),
        .loadValue_i (credit_initial),
        .incr_i      (pop_credit),
        .decr_i      (push_credit),
        .count_o     (credit_count),
        .saturated_o (countSat)
    );

`ifdef CREDIT_RECEIVER_MC_ERROR_CHECK_EN

    localparam logic [CW-1:0] MAX_CREDITS_CW = CW'(MAX_CREDITS);

    logic [CW-1:0] outstanding;
    logic          unusedOutstandingSat;
    logic          creditError_q;
    logic          creditError_d;

    credit_receiver_counter #(
        .WIDTH      (CW),
        .INCR_WIDTH (1),
        .MAX_VALUE  (MAX_CREDITS)
    ) outstandingCounter (
        .clk         (clk),
        .rst         (rst),
        .enable_i    (isActive),
        .load_i      (!isActive || push_sender_in_reset),
        .loadValue_i ('0),
        .incr_i      (push_credit),
        .decr_i      (pop_valid),
        .count_o     (outstanding),
        .saturated_o (unusedOutstandingSat)
    );

    // Sticky error: data without a credit, credit overflow, or an oversized initial load.
    always_comb begin
        creditError_d = creditError_q;
        if (pop_valid && (outstanding == '0) && !push_credit) begin
            creditError_d = 1'b1;
        end
        if (isActive && countSat) begin
            creditError_d = 1'b1;
        end
        if (loadInitial && (credit_initial > MAX_CREDITS_CW)) begin
            creditError_d = 1'b1;
        end
    end

    // Error flag register; only the main reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            creditError_q <= 1'b0;
        end else begin
            creditError_q <= creditError_d;
        end
    end

    assign credit_error = creditError_q;

`else

    logic unusedCountSat;
    assign unusedCountSat = countSat;
    assign credit_error   = 1'b0;

`endif

endmodule

// File: tb/tb_credit_receiver_mc.sv
// Self-checking bench for credit_receiver_mc: a directed vector table, a few
// hand-written multi-cycle sequences, and randomized traffic compared against
// a behavioural model of the credit rules.
module tb_credit_receiver_mc;

    localparam int DW     = 8;
    localparam int MAXC   = 8;
    localparam int POPMAX = 3;
    localparam int CW     = 4;
    localparam int IW     = 2;

`ifdef CREDIT_RECEIVER_MC_ERROR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    localparam int M_RESET  = 0;
    localparam int M_WAIT   = 1;
    localparam int M_ACTIVE = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          push_sender_in_reset;
    logic          push_receiver_in_reset;
    logic          push_credit_stall;
    logic          push_credit;
    logic          push_valid;
    logic [DW-1:0] push_data;
    logic          pop_valid;
    logic [DW-1:0] pop_data;
    logic [IW-1:0] pop_credit;
    logic [CW-1:0] credit_initial;
    logic [CW-1:0] credit_withhold;
    logic [CW-1:0] credit_count;
    logic [CW-1:0] credit_available;
    logic          credit_error;

    credit_receiver_mc #(
        .DATA_WIDTH          (DW),
        .MAX_CREDITS         (MAXC),
        .POP_CREDIT_MAX_INCR (POPMAX)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .push_sender_in_reset   (push_sender_in_reset),
        .push_receiver_in_reset (push_receiver_in_reset),
        .push_credit_stall      (push_credit_stall),
        .push_credit            (push_credit),
        .push_valid             (push_valid),
        .push_data              (push_data),
        .pop_valid              (pop_valid),
        .pop_data               (pop_data),
        .pop_credit             (pop_credit),
        .credit_initial         (credit_initial),
        .credit_withhold        (credit_withhold),
        .credit_count           (credit_count),
        .credit_available       (credit_available),
        .credit_error           (credit_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            sir;
        bit            stall;
        bit            pushValid;
        logic [DW-1:0] data;
        int            popCredit;
        int            creditInit;
        int            withhold;
    } stim_t;

    typedef struct {
        stim_t s;
        int    expRir;
        int    expPc;
        int    expPv;
        int    expCount;
        int    expAvail;
        int    expErr;
    } vector_t;

    int checkCount = 0;
    int passCount  = 0;

    // Behavioural model of the receiver
    int mMode;
    int mCount;
    int mOut;
    bit mErr;

    // Outputs sampled in the most recent cycle
    int snapRir, snapPc, snapPv, snapData, snapCount, snapAvail, snapErr;

    function automatic stim_t mk(input bit sir, input bit stall, input bit pv,
                                 input logic [DW-1:0] data, input int pop,
                                 input int init, input int wh);
        stim_t s;
        s.sir = sir; s.stall = stall; s.pushValid = pv; s.data = data;
        s.popCredit = pop; s.creditInit = init; s.withhold = wh;
        return s;
    endfunction

    function automatic vector_t mkVec(input stim_t s, input int rir, input int pc,
                                      input int pv, input int cnt, input int av,
                                      input int err);
        vector_t v;
        v.s = s; v.expRir = rir; v.expPc = pc; v.expPv = pv;
        v.expCount = cnt; v.expAvail = av; v.expErr = err;
        return v;
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        checkCount++;
        if (act == exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input stim_t s);
        push_sender_in_reset = s.sir;
        push_credit_stall    = s.stall;
        push_valid           = s.pushValid;
        push_data            = s.data;
        pop_credit           = IW'(s.popCredit);
        credit_initial       = CW'(s.creditInit);
        credit_withhold      = CW'(s.withhold);
    endtask

    task automatic sampleOutputs();
        snapRir   = int'(push_receiver_in_reset);
        snapPc    = int'(push_credit);
        snapPv    = int'(pop_valid);
        snapData  = int'(pop_data);
        snapCount = int'(credit_count);
        snapAvail = int'(credit_available);
        snapErr   = int'(credit_error);
    endtask

    // Advance the model by one clock edge using the credit rules directly.
    task automatic modelStep(input stim_t s, input int pc, input int pv);
        int next;
        case (mMode)
            M_RESET: mMode = M_WAIT;
            M_WAIT: begin
                mCount = s.creditInit;
                if (s.creditInit > MAXC) mErr = mErr | ERR_EN;
                if (!s.sir) mMode = M_ACTIVE;
            end
            default: begin
                if (pv == 1 && mOut == 0 && pc == 0) mErr = mErr | ERR_EN;
                next = mCount + s.popCredit - pc;
                if (next > MAXC) begin
                    mCount = MAXC;
                    mErr   = mErr | ERR_EN;
                end else begin
                    mCount = next;
                end
                mOut = mOut + pc - pv;
                if (mOut < 0) mOut = 0;
                if (mOut > MAXC) mOut = MAXC;
                if (s.sir) begin
                    mMode = M_WAIT;
                    mOut  = 0;
                end
            end
        endcase
    endtask

    // One clock cycle: drive at the falling edge, compare against the model, step at the rising edge.
    task automatic runCycle(input stim_t s, input string tag);
        int avail;
        int pc;
        int pv;
        applyStimulus(s);
        #1;
        sampleOutputs();
        avail = (mCount > s.withhold) ? (mCount - s.withhold) : 0;
        pc    = (mMode == M_ACTIVE && !s.stall && avail != 0) ? 1 : 0;
        pv    = (mMode == M_ACTIVE && s.pushValid) ? 1 : 0;
        checkOutput({tag, ".rcvInReset"}, snapRir, (mMode == M_RESET) ? 1 : 0);
        checkOutput({tag, ".pushCredit"}, snapPc, pc);
        checkOutput({tag, ".popValid"}, snapPv, pv);
        checkOutput({tag, ".popData"}, snapData, int'(s.data));
        checkOutput({tag, ".count"}, snapCount, mCount);
        checkOutput({tag, ".available"}, snapAvail, avail);
        checkOutput({tag, ".error"}, snapErr, int'(mErr));
        @(posedge clk);
        modelStep(s, pc, pv);
        @(negedge clk);
    endtask

    // Asynchronous reset pulse issued between clock edges.
    task automatic pulseReset(input string tag);
        push_valid        = 1'b1;
        push_credit_stall = 1'b0;
        rst = 1'b1;
        #1;
        mMode = M_RESET; mCount = 0; mOut = 0; mErr = 1'b0;
        sampleOutputs();
        checkOutput({tag, ".rcvInReset"}, snapRir, 1);
        checkOutput({tag, ".count"}, snapCount, 0);
        checkOutput({tag, ".pushCredit"}, snapPc, 0);
        checkOutput({tag, ".popValid"}, snapPv, 0);
        checkOutput({tag, ".error"}, snapErr, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    vector_t vecs[13];

    initial begin
        stim_t s;
        rst = 1'b1;
        applyStimulus(mk(1, 0, 1, 8'h11, 0, 5, 2));

        // Directed table: reset, initial load, credit return, pop increments, saturation
        vecs[0]  = mkVec(mk(1, 0, 1, 8'h11, 0, 5, 2), 1, 0, 0, 0, 0, 0);
        vecs[1]  = mkVec(mk(1, 0, 0, 8'h22, 0, 5, 2), 0, 0, 0, 0, 0, 0);
        vecs[2]  = mkVec(mk(0, 0, 0, 8'h33, 0, 5, 2), 0, 0, 0, 5, 3, 0);
        vecs[3]  = mkVec(mk(0, 0, 0, 8'h44, 0, 5, 2), 0, 1, 0, 5, 3, 0);
        vecs[4]  = mkVec(mk(0, 0, 0, 8'h55, 0, 5, 2), 0, 1, 0, 4, 2, 0);
        vecs[5]  = mkVec(mk(0, 0, 0, 8'h66, 0, 5, 2), 0, 1, 0, 3, 1, 0);
        vecs[6]  = mkVec(mk(0, 0, 0, 8'h77, 0, 5, 2), 0, 0, 0, 2, 0, 0);
        vecs[7]  = mkVec(mk(0, 0, 0, 8'h88, 3, 5, 2), 0, 0, 0, 2, 0, 0);
        vecs[8]  = mkVec(mk(0, 0, 0, 8'h99, 0, 5, 2), 0, 1, 0, 5, 3, 0);
        vecs[9]  = mkVec(mk(0, 1, 0, 8'hAA, 3, 5, 2), 0, 0, 0, 4, 2, 0);
        vecs[10] = mkVec(mk(0, 1, 0, 8'hBB, 1, 5, 2), 0, 0, 0, 7, 5, 0);
        vecs[11] = mkVec(mk(0, 1, 0, 8'hCC, 1, 5, 2), 0, 0, 0, 8, 6, 0);
        vecs[12] = mkVec(mk(0, 1, 0, 8'hDD, 0, 5, 2), 0, 0, 0, 8, 6, int'(ERR_EN));

        pulseReset("powerOn");
        for (int i = 0; i < 13; i++) begin
            runCycle(vecs[i].s, $sformatf("vec%0d", i));
            checkOutput($sformatf("vec%0d.tblRir", i), snapRir, vecs[i].expRir);
            checkOutput($sformatf("vec%0d.tblPushCredit", i), snapPc, vecs[i].expPc);
            checkOutput($sformatf("vec%0d.tblPopValid", i), snapPv, vecs[i].expPv);
            checkOutput($sformatf("vec%0d.tblCount", i), snapCount, vecs[i].expCount);
            checkOutput($sformatf("vec%0d.tblAvail", i), snapAvail, vecs[i].expAvail);
            checkOutput($sformatf("vec%0d.tblError", i), snapErr, vecs[i].expErr);
        end

        // Data with no outstanding credit: forwarded at once, error one cycle later
        pulseReset("errClear");
        runCycle(mk(1, 0, 0, 8'h00, 0, 3, 8), "noCred0");
        runCycle(mk(1, 0, 0, 8'h00, 0, 3, 8), "noCred1");
        runCycle(mk(0, 0, 0, 8'h00, 0, 3, 8), "noCred2");
        runCycle(mk(0, 0, 1, 8'hA5, 0, 3, 8), "noCred3");
        checkOutput("noCred.popValid", snapPv, 1);
        checkOutput("noCred.popData", snapData, 8'hA5);
        checkOutput("noCred.errorBefore", snapErr, 0);
        runCycle(mk(0, 0, 0, 8'h5A, 0, 3, 8), "noCred4");
        checkOutput("noCred.errorAfter", snapErr, int'(ERR_EN));

        // Sender reset in the middle of traffic
        for (int i = 0; i < 4; i++) begin
            runCycle(mk(0, 0, 1, 8'(i * 37 + 1), 1, 7, 0), $sformatf("traffic%0d", i));
        end
        runCycle(mk(1, 0, 0, 8'h10, 1, 7, 0), "sndRst0");
        runCycle(mk(1, 0, 1, 8'h20, 1, 7, 0), "sndRst1");
        checkOutput("sndRst.popValid", snapPv, 0);
        checkOutput("sndRst.pushCredit", snapPc, 0);
        checkOutput("sndRst.rcvInReset", snapRir, 0);
        runCycle(mk(1, 0, 1, 8'h30, 1, 7, 0), "sndRst2");
        checkOutput("sndRst.count", snapCount, 7);
        checkOutput("sndRst.pushCreditHeld", snapPc, 0);
        checkOutput("sndRst.errorKept", snapErr, int'(ERR_EN));
        runCycle(mk(0, 0, 0, 8'h40, 0, 7, 0), "sndRst3");

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            if (i == 200) pulseReset("midReset");
            s = mk(($urandom_range(15) == 0), ($urandom_range(3) == 0),
                   ($urandom_range(1) == 1), 8'($urandom_range(255)),
                   int'($urandom_range(POPMAX)), int'($urandom_range(10)),
                   int'($urandom_range(9)));
            runCycle(s, $sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
